// File: rtl/m6809_bus_fabric.sv
// ---------------------------------------------------------------------------
// m6809_bus_fabric
//   Table-driven memory-map fabric between the 6809 core and NUM_REGIONS
//   devices. Each region has a base, compare mask and wait-state count.
//   Accesses are stretched over the wait states with a request/ready
//   handshake. Unmapped accesses end with a bus error and DEFAULT_RDATA.
//
//   Region i uses slice [i*ADDR_W +: ADDR_W] of REGION_BASE / REGION_MASK
//   and slice [i*4 +: 4] of REGION_WAIT (region 0 is the least significant
//   slice). The lowest matching enabled region wins.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   cpu_req/addr/wdata  core request, address, write data
//   cpu_rw_n            1 = read, 0 = write
//   cpu_rdata           registered read data, valid with cpu_ready
//   cpu_ready           one-cycle completion pulse
//   cpu_berr            qualifies cpu_ready: access was unmapped
//   dev_sel             one-hot device select for the whole access
//   dev_addr/wdata/wr_n latched access fields
//   dev_last            final device cycle (write commit / read sample)
//   dev_rdata           flat per-device read data
//   berr_addr/flag/clr  sticky bus-error capture
//
// Optional feature macro: M6809_FABRIC_BERR_CAPTURE_EN
//   Defined   : berr_addr/berr_flag capture the most recent bus error.
//   Undefined : berr_addr = 0, berr_flag = 0, berr_clr ignored.
// ---------------------------------------------------------------------------
module m6809_bus_fabric #(
    parameter int                                ADDR_W        = 16,
    parameter int                                DATA_W        = 8,
    parameter int                                NUM_REGIONS   = 4,
    parameter logic [NUM_REGIONS-1:0]            REGION_EN     = 4'b0111,
    parameter logic [NUM_REGIONS*ADDR_W-1:0]     REGION_BASE   = {16'h0000, 16'h8000, 16'hFF00, 16'h0000},
    parameter logic [NUM_REGIONS*ADDR_W-1:0]     REGION_MASK   = {16'h0000, 16'hF000, 16'hFF00, 16'hFF00},
    parameter logic [NUM_REGIONS*4-1:0]          REGION_WAIT   = {4'd0, 4'd1, 4'd3, 4'd0},
    parameter logic [DATA_W-1:0]                 DEFAULT_RDATA = 8'hFF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cpu_req,
    input  logic [ADDR_W-1:0]             cpu_addr,
    input  logic [DATA_W-1:0]             cpu_wdata,
    input  logic                          cpu_rw_n,
    output logic [DATA_W-1:0]             cpu_rdata,
    output logic                          cpu_ready,
    output logic                          cpu_berr,
    output logic [NUM_REGIONS-1:0]        dev_sel,
    output logic [ADDR_W-1:0]             dev_addr,
    output logic [DATA_W-1:0]             dev_wdata,
    output logic                          dev_wr_n,
    output logic                          dev_last,
    input  logic [NUM_REGIONS*DATA_W-1:0] dev_rdata,
    output logic [ADDR_W-1:0]             berr_addr,
    output logic                          berr_flag,
    input  logic                          berr_clr
);

    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [DATA_W-1:0]        wdata_q, wdata_d;
    logic                     wr_n_q, wr_n_d;
    logic [DATA_W-1:0]        rdata_q, rdata_d;
    logic [NUM_REGIONS-1:0]   sel_q, sel_d;
    logic                     last_q, last_d;
    logic                     ready_q, ready_d;
    logic                     berr_q, berr_d;
    logic                     hit_s;
    logic [IDX_W-1:0]         hit_idx_s;

    function automatic logic [3:0] region_wait(input logic [IDX_W-1:0] idx);
        return REGION_WAIT[int'(idx)*4 +: 4];
    endfunction

    function automatic logic [NUM_REGIONS-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return NUM_REGIONS'(1) << idx;
    endfunction

    // Address decoder: scan from the top so the lowest matching index wins.
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (REGION_EN[i] &&
                ((cpu_addr & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W])) begin
                hit_s     = 1'b1;
                hit_idx_s = IDX_W'(i);
            end else begin
                hit_s     = hit_s;
                hit_idx_s = hit_idx_s;
            end
        end
    end

    // Next-state logic; registered outputs are derived from the next state
    // so they line up with the state they belong to.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_n_d  = wr_n_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    addr_d = cpu_addr;
                    if (hit_s) begin
                        idx_d   = hit_idx_s;
                        cnt_d   = region_wait(hit_idx_s);
                        wdata_d = cpu_wdata;
                        wr_n_d  = cpu_rw_n;
                        state_d = S_ACCESS;
                    end else begin
                        rdata_d = DEFAULT_RDATA;
                        state_d = S_ERR;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Final device cycle: reads sample the selected device.
                    if (wr_n_q) begin
                        rdata_d = dev_rdata[int'(idx_q)*DATA_W +: DATA_W];
                    end else begin
                        rdata_d = rdata_q;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        sel_d   = (state_d == S_ACCESS) ? idx_to_onehot(idx_d) : '0;
        last_d  = (state_d == S_ACCESS) && (cnt_d == 4'd0);
        ready_d = (state_d == S_DONE) || (state_d == S_ERR);
        berr_d  = (state_d == S_ERR);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_n_q  <= 1'b1;
            rdata_q <= '0;
            sel_q   <= '0;
            last_q  <= 1'b0;
            ready_q <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_n_q  <= wr_n_d;
            rdata_q <= rdata_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            ready_q <= ready_d;
            berr_q  <= berr_d;
        end
    end

    assign cpu_rdata = rdata_q;
    assign cpu_ready = ready_q;
    assign cpu_berr  = berr_q;
    assign dev_sel   = sel_q;
    assign dev_addr  = addr_q;
    assign dev_wdata = wdata_q;
    assign dev_wr_n  = wr_n_q;
    assign dev_last  = last_q;

`ifdef M6809_FABRIC_BERR_CAPTURE_EN
    logic [ADDR_W-1:0] berr_addr_q, berr_addr_d;
    logic              berr_flag_q, berr_flag_d;

    // Sticky capture: a new error takes priority over a clear in the same cycle.
    always_comb begin
        berr_addr_d = berr_addr_q;
        berr_flag_d = berr_flag_q;
        if ((state_q == S_IDLE) && (state_d == S_ERR)) begin
            berr_addr_d = cpu_addr;
            berr_flag_d = 1'b1;
        end else if (berr_clr) begin
            berr_flag_d = 1'b0;
        end else begin
            berr_flag_d = berr_flag_q;
        end
    end

    // Bus-error capture registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            berr_addr_q <= '0;
            berr_flag_q <= 1'b0;
        end else begin
            berr_addr_q <= berr_addr_d;
            berr_flag_q <= berr_flag_d;
        end
    end

    assign berr_addr = berr_addr_q;
    assign berr_flag = berr_flag_q;
`else
    logic berr_clr_unused_s;
    assign berr_clr_unused_s = berr_clr;
    assign berr_addr = '0;
    assign berr_flag = 1'b0;
`endif

endmodule

// File: tb/tb_m6809_bus_fabric.sv
// ---------------------------------------------------------------------------
// Self-checking bench for m6809_bus_fabric. Expected completions are pushed
// to a scoreboard queue when a request is driven and popped when cpu_ready
// pulses. Region map used here: r0 = 0x00xx (0 waits), r1 = 0x8xxx (1 wait),
// r2 = 0xFFxx (3 waits), r3 disabled.
// ---------------------------------------------------------------------------
module tb_m6809_bus_fabric;

    typedef struct {
        logic [7:0] rdata;
        logic       berr;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        cpu_rw_n = 1'b1;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready;
    logic        cpu_berr;
    logic [3:0]  dev_sel;
    logic [15:0] dev_addr;
    logic [7:0]  dev_wdata;
    logic        dev_wr_n;
    logic        dev_last;
    logic [31:0] dev_rdata = 32'h0000_0000;
    logic [15:0] berr_addr;
    logic        berr_flag;
    logic        berr_clr = 1'b0;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic [7:0] model_rdata = 8'h00;
    exp_t sb_q[$];

    m6809_bus_fabric #(
        .ADDR_W        (16),
        .DATA_W        (8),
        .NUM_REGIONS   (4),
        .REGION_EN     (4'b0111),
        .REGION_BASE   ({16'h0000, 16'hFF00, 16'h8000, 16'h0000}),
        .REGION_MASK   ({16'hFF00, 16'hFF00, 16'hF000, 16'hFF00}),
        .REGION_WAIT   ({4'd0, 4'd3, 4'd1, 4'd0}),
        .DEFAULT_RDATA (8'hFF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rw_n  (cpu_rw_n),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .cpu_berr  (cpu_berr),
        .dev_sel   (dev_sel),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .dev_wr_n  (dev_wr_n),
        .dev_last  (dev_last),
        .dev_rdata (dev_rdata),
        .berr_addr (berr_addr),
        .berr_flag (berr_flag),
        .berr_clr  (berr_clr)
    );

    always #5 clk = ~clk;

    // Cycle counter: value after each rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [56:0] RESET_VEC = {4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000,
                                         8'h00, 1'b1, 16'h0000, 1'b0};

    function automatic logic [56:0] out_vec();
        return {dev_sel, dev_last, cpu_ready, cpu_berr, cpu_rdata, dev_addr,
                dev_wdata, dev_wr_n, berr_addr, berr_flag};
    endfunction

    // One access from an idle fabric; region < 0 means unmapped.
    task automatic run_access(input logic [15:0] addr, input logic [7:0] wd, input logic rw_n,
                              input int region, input int wait_n, input string name);
        exp_t       e;
        logic [3:0] exp_sel;
        int         sel_cycles;
        int         bad_sel;
        int         last_cycles;
        int         last_at;
        bit         done;
        sel_cycles  = 0;
        bad_sel     = 0;
        last_cycles = 0;
        last_at     = -1;
        done        = 1'b0;
        exp_sel     = (region >= 0) ? (4'b0001 << region) : 4'b0000;
        if (region < 0)      e.rdata = 8'hFF;
        else if (rw_n)       e.rdata = dev_rdata[region*8 +: 8];
        else                 e.rdata = model_rdata;
        e.berr = (region < 0);
        model_rdata = e.rdata;

        @(posedge clk); #1;
        cpu_req   = 1'b1;
        cpu_addr  = addr;
        cpu_wdata = wd;
        cpu_rw_n  = rw_n;
        e.cyc = cyc + 1 + ((region < 0) ? 0 : wait_n + 1);
        sb_q.push_back(e);

        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (k == 1) cpu_req = 1'b0;
            if (dev_sel != 4'b0000) begin
                if (dev_sel == exp_sel) sel_cycles++;
                else bad_sel++;
            end
            if (dev_last) begin
                last_cycles++;
                last_at = sel_cycles;
                checks++;
                if (dev_addr !== addr || dev_wr_n !== rw_n || (!rw_n && dev_wdata !== wd)) begin
                    errors++;
                    $display("FAIL %s dev_fields: addr=%h wr_n=%b wdata=%h required addr=%h wr_n=%b wdata=%h",
                             name, dev_addr, dev_wr_n, dev_wdata, addr, rw_n, wd);
                end
            end
            if (cpu_ready) begin
                e = sb_q.pop_front();
                done = 1'b1;
                checks++;
                if (cpu_rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL %s rdata: got %h required %h", name, cpu_rdata, e.rdata);
                end
                checks++;
                if (cpu_berr !== e.berr) begin
                    errors++;
                    $display("FAIL %s berr: got %b required %b", name, cpu_berr, e.berr);
                end
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL %s ready_cycle: got %0d required %0d", name, cyc, e.cyc);
                end
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: no cpu_ready within 40 cycles", name);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end
        checks++;
        if (sel_cycles != ((region < 0) ? 0 : wait_n + 1) || bad_sel != 0) begin
            errors++;
            $display("FAIL %s dev_sel: %0d cycles (%0d wrong) required %0d cycles of %b",
                     name, sel_cycles, bad_sel, (region < 0) ? 0 : wait_n + 1, exp_sel);
        end
        checks++;
        if (region >= 0 && (last_cycles != 1 || last_at != wait_n + 1)) begin
            errors++;
            $display("FAIL %s dev_last: %0d pulses at sel cycle %0d required 1 at %0d",
                     name, last_cycles, last_at, wait_n + 1);
        end else if (region < 0 && last_cycles != 0) begin
            errors++;
            $display("FAIL %s dev_last: %0d pulses required 0", name, last_cycles);
        end
    endtask

    task automatic test_reset();
        int stray;
        stray = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_vec() !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_init: got %h required %h", out_vec(), RESET_VEC);
        end
        reset = 1'b0;
        // Reset in the middle of a 2-cycle access to 0x8000.
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_addr = 16'h8000; cpu_rw_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (dev_sel !== 4'b0010) begin
            errors++;
            $display("FAIL reset_pre_access dev_sel: got %b required 0010", dev_sel);
        end
        reset = 1'b1;
        cpu_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_vec() !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_mid_access: got %h required %h", out_vec(), RESET_VEC);
        end
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (cpu_ready || dev_last || dev_sel != 4'b0000) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL reset_abandon: %0d stray cycles required 0", stray);
        end
    endtask

    task automatic test_read_dev0();
        dev_rdata = {8'hD3, 8'hE2, 8'hB4, 8'h5A};
        run_access(16'h0012, 8'h00, 1'b1, 0, 0, "read_dev0");
    endtask

    task automatic test_write_dev1();
        dev_rdata = {8'hD3, 8'hE2, 8'hB4, 8'h66};
        run_access(16'h8004, 8'hC3, 1'b0, 1, 1, "write_dev1");
    endtask

    task automatic test_read_dev2();
        dev_rdata = {8'hD3, 8'h80, 8'hB4, 8'h5A};
        run_access(16'hFFFE, 8'h00, 1'b1, 2, 3, "read_dev2");
    endtask

    task automatic test_unmapped();
        run_access(16'h4000, 8'h00, 1'b1, -1, 0, "unmapped");
    endtask

    task automatic test_berr_capture();
`ifdef M6809_FABRIC_BERR_CAPTURE_EN
        logic       exp_flag_after_clr = 1'b0;
        logic       exp_flag = 1'b1;
        logic [15:0] exp_addr = 16'h4000;
`else
        logic       exp_flag_after_clr = 1'b0;
        logic       exp_flag = 1'b0;
        logic [15:0] exp_addr = 16'h0000;
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (berr_flag !== exp_flag || berr_addr !== exp_addr) begin
            errors++;
            $display("FAIL berr_capture: flag=%b addr=%h required flag=%b addr=%h",
                     berr_flag, berr_addr, exp_flag, exp_addr);
        end
        berr_clr = 1'b1;
        @(negedge clk);
        berr_clr = 1'b0;
        checks++;
        if (berr_flag !== exp_flag_after_clr) begin
            errors++;
            $display("FAIL berr_clear: flag=%b required %b", berr_flag, exp_flag_after_clr);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   c_t;
        int   pulses;
        int   last_ready;
        pulses = 0;
        last_ready = 0;
        dev_rdata = {8'hD3, 8'hE2, 8'hB4, 8'h11};
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_addr = 16'h0001; cpu_rw_n = 1'b1;
        c_t = cyc + 1;
        e.rdata = 8'h11; e.berr = 1'b0; e.cyc = c_t + 1;
        sb_q.push_back(e);
        e.rdata = 8'h22; e.berr = 1'b0; e.cyc = c_t + 4;
        sb_q.push_back(e);
        for (int k = 0; k < 30 && pulses < 2; k++) begin
            @(negedge clk);
            if (cyc == c_t + 3) cpu_req = 1'b0;
            if (cpu_ready) begin
                pulses++;
                e = sb_q.pop_front();
                checks++;
                if (cpu_rdata !== e.rdata || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL b2b_ready%0d: rdata=%h cycle=%0d required rdata=%h cycle=%0d",
                             pulses, cpu_rdata, cyc, e.rdata, e.cyc);
                end
                if (pulses == 2) begin
                    checks++;
                    if (cyc - last_ready != 3) begin
                        errors++;
                        $display("FAIL b2b_spacing: got %0d required 3", cyc - last_ready);
                    end
                end
                last_ready = cyc;
                cpu_addr  = 16'h0002;
                dev_rdata = {8'hD3, 8'hE2, 8'hB4, 8'h22};
            end
        end
        cpu_req = 1'b0;
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d required 2", pulses);
            sb_q.delete();
        end
        repeat (4) @(negedge clk);
        checks++;
        if (sb_q.size() != 0 || cpu_ready) begin
            errors++;
            $display("FAIL b2b_drain: queue=%0d ready=%b required 0 and 0", sb_q.size(), cpu_ready);
        end
    endtask

    initial begin
        test_reset();
        test_read_dev0();
        test_write_dev1();
        test_read_dev2();
        test_unmapped();
        test_berr_capture();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
